// File: rtl/norm_pkg.sv
// Shared widths, helper functions and the result record for the normalizing arbiter.
package norm_pkg;

  localparam int NORM_DATA_W = 8;
  localparam int NORM_NREQ   = 4;

  function automatic int calc_cnt_w(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

  function automatic int calc_id_w(input int nreq);
    return $clog2(nreq);
  endfunction

  // Result record sized for the default configuration.
  typedef struct packed {
    logic [NORM_DATA_W-1:0]             data;
    logic [calc_cnt_w(NORM_DATA_W)-1:0] shift;
    logic                               zero;
    logic [calc_id_w(NORM_NREQ)-1:0]    id;
  } norm_res_t;

endpackage

// File: rtl/norm_lzc_shift.sv
// Combinational leading-zero count and left-justify of one data word.
module norm_lzc_shift
  import norm_pkg::*;
#(
  parameter int DATA_W = NORM_DATA_W,
  parameter int CNT_W  = calc_cnt_w(DATA_W)
) (
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] norm_data,
  output logic [CNT_W-1:0]  norm_shift,
  output logic              norm_zero
);

  logic [CNT_W-1:0] cnt_s;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    cnt_s = CNT_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      cnt_s = in_data[i] ? CNT_W'(DATA_W - 1 - i) : cnt_s;
    end
  end

  assign norm_shift = cnt_s;
  assign norm_zero  = ~|in_data;
  assign norm_data  = in_data << cnt_s;

endmodule

// File: rtl/norm_arbiter.sv
// Round-robin arbiter sharing one leading-zero normalizer, with a single
// registered output stage that supports backpressure.
module norm_arbiter
  import norm_pkg::*;
#(
  parameter int DATA_W = NORM_DATA_W,
  parameter int NREQ   = NORM_NREQ,
  parameter int CNT_W  = calc_cnt_w(DATA_W),
  parameter int ID_W   = calc_id_w(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CNT_W-1:0]         out_shift,
  output logic                     out_zero,
  output logic [ID_W-1:0]          out_id
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  shift;
    logic              zero;
    logic [ID_W-1:0]   id;
  } res_t;

  res_t            res_q, res_d;
  logic            valid_q, valid_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic              can_load_s;
  logic              gnt_found_s;
  logic              gnt_valid_s;
  logic [ID_W-1:0]   gnt_idx_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [DATA_W-1:0] norm_data_s;
  logic [CNT_W-1:0]  norm_shift_s;
  logic              norm_zero_s;

  assign can_load_s = ~valid_q | out_ready;

  // Scan requesters starting at the round-robin pointer, wrapping explicitly.
  always_comb begin
    int idx_v;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = int'(rr_ptr_q) + k;
      idx_v = (idx_v >= NREQ) ? (idx_v - NREQ) : idx_v;
      if (!gnt_found_s && req_valid[idx_v]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = ID_W'(idx_v);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
  end

  assign gnt_valid_s = rst_n & can_load_s & gnt_found_s;
  assign req_ready   = gnt_valid_s ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s) : '0;
  assign sel_data_s  = req_data[int'(gnt_idx_s)*DATA_W +: DATA_W];

  norm_lzc_shift #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_lzc (
    .in_data    (sel_data_s),
    .norm_data  (norm_data_s),
    .norm_shift (norm_shift_s),
    .norm_zero  (norm_zero_s)
  );

  // Load on grant, drain when popped with nothing new, otherwise hold.
  always_comb begin
    res_d    = res_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid_s) begin
      res_d.data  = norm_data_s;
      res_d.shift = norm_shift_s;
      res_d.zero  = norm_zero_s;
      res_d.id    = gnt_idx_s;
      valid_d     = 1'b1;
      rr_ptr_d    = (int'(gnt_idx_s) == NREQ - 1) ? '0 : gnt_idx_s + ID_W'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output stage and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      valid_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      res_q    <= res_d;
      valid_q  <= valid_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = res_q.data;
  assign out_shift = res_q.shift;
  assign out_zero  = res_q.zero;
  assign out_id    = res_q.id;

endmodule

// File: tb/tb_norm_arbiter.sv
// Directed bench for norm_arbiter: expected results queued at grant time,
// popped and compared by a monitor whenever the output stage is accepted.
module tb_norm_arbiter;
  import norm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [3:0]  out_shift;
  logic        out_zero;
  logic [1:0]  out_id;

  int tests = 0;
  int fails = 0;
  norm_res_t sb[$];

  norm_arbiter #(.DATA_W(8), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; checks req_ready/out_valid and queues the expected result.
  task automatic step(input logic [3:0] v, input logic [31:0] d, input logic ordy,
                      input logic exp_ov, input logic [3:0] exp_rdy,
                      input logic [7:0] ed, input logic [3:0] es, input logic ez,
                      input logic [1:0] eid);
    norm_res_t e;
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
    @(negedge clk);
    check("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_rdy != 4'd0) begin
      e.data = ed; e.shift = es; e.zero = ez; e.id = eid;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output must match the oldest queued expectation.
  always @(negedge clk) begin
    norm_res_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got id %0d data %0h with empty queue", out_id, out_data);
      end else begin
        e = sb.pop_front();
        check("out_data",  {24'd0, out_data},  {24'd0, e.data});
        check("out_shift", {28'd0, out_shift}, {28'd0, e.shift});
        check("out_zero",  {31'd0, out_zero},  {31'd0, e.zero});
        check("out_id",    {30'd0, out_id},    {30'd0, e.id});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ALL_D = {8'h0F, 8'h40, 8'h25, 8'hFF};

  initial begin
    rst_n = 1'b0; req_valid = 4'hF; req_data = 32'd0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_out_shift", {28'd0, out_shift}, 32'd0);
    check("rst_out_zero",  {31'd0, out_zero},  32'd0);
    check("rst_out_id",    {30'd0, out_id},    32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    req_valid = 4'h0;
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request, zero input, MSB already set, drain
    step(4'b0001, 32'h0000_0016, 1'b1, 1'b0, 4'b0001, 8'hB0, 4'd3, 1'b0, 2'd0);
    step(4'b0100, 32'h0000_0000, 1'b1, 1'b1, 4'b0100, 8'h00, 4'd8, 1'b1, 2'd2);
    step(4'b0010, 32'h0000_8000, 1'b1, 1'b1, 4'b0010, 8'h80, 4'd0, 1'b0, 2'd1);
    step(4'b0000, 32'h0000_0000, 1'b1, 1'b1, 4'b0000, 8'h00, 4'd0, 1'b0, 2'd0);
    // Move pointer to 0 via requester 3
    step(4'b1000, 32'h0100_0000, 1'b1, 1'b0, 4'b1000, 8'h80, 4'd7, 1'b0, 2'd3);
    // Full load round robin: 0,1,2,3,0,1 with no bubbles
    step(4'hF, ALL_D, 1'b1, 1'b1, 4'b0001, 8'hFF, 4'd0, 1'b0, 2'd0);
    step(4'hF, ALL_D, 1'b1, 1'b1, 4'b0010, 8'h94, 4'd2, 1'b0, 2'd1);
    step(4'hF, ALL_D, 1'b1, 1'b1, 4'b0100, 8'h80, 4'd1, 1'b0, 2'd2);
    step(4'hF, ALL_D, 1'b1, 1'b1, 4'b1000, 8'hF0, 4'd4, 1'b0, 2'd3);
    step(4'hF, ALL_D, 1'b1, 1'b1, 4'b0001, 8'hFF, 4'd0, 1'b0, 2'd0);
    step(4'hF, ALL_D, 1'b1, 1'b1, 4'b0010, 8'h94, 4'd2, 1'b0, 2'd1);
    // Backpressure: requester-1 result held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(4'b1010, ALL_D, 1'b0, 1'b1, 4'b0000, 8'h00, 4'd0, 1'b0, 2'd0);
      check("hold_data",  {24'd0, out_data},  32'h94);
      check("hold_shift", {28'd0, out_shift}, 32'd2);
      check("hold_id",    {30'd0, out_id},    32'd1);
    end
    // Release: next after requester 1 among {1,3} is 3
    step(4'b1010, ALL_D, 1'b1, 1'b1, 4'b1000, 8'hF0, 4'd4, 1'b0, 2'd3);
    // Pointer to 2 with a held result, then async reset
    step(4'b0010, ALL_D, 1'b1, 1'b1, 4'b0010, 8'h94, 4'd2, 1'b0, 2'd1);
    step(4'b0000, ALL_D, 1'b0, 1'b1, 4'b0000, 8'h00, 4'd0, 1'b0, 2'd0);
    req_valid = 4'hF;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data",  {24'd0, out_data},  32'd0);
    check("midrst_req_ready", {28'd0, req_ready}, 32'd0);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(4'hF, ALL_D, 1'b1, 1'b0, 4'b0001, 8'hFF, 4'd0, 1'b0, 2'd0);
    step(4'h0, ALL_D, 1'b1, 1'b1, 4'b0000, 8'h00, 4'd0, 1'b0, 2'd0);
    step(4'h0, ALL_D, 1'b1, 1'b0, 4'b0000, 8'h00, 4'd0, 1'b0, 2'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
